alu_issue_stage: RTL and testbench

- ID/EX boundary block that feeds the ALU.
- Each cycle it decodes one RV32 instruction word into the ALU 4-bit control code and selects the two ALU operands (register or immediate).
- It registers the decoded bundle into the EX pipeline register, with stall, flush, illegal-instruction flagging and sticky halt detection (ECALL/EBREAK).
- The registered outputs drive the ALU inputs directly.

---
 rtl/alu_issue_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes one RV32 word per cycle into an ALU control code
// plus operands and registers the bundle into the EX pipeline register.
module alu_issue_stage #(
  parameter int unsigned XLEN           = 32,
  parameter bit          HALT_ON_EBREAK = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [3:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_inp1,
  output logic [XLEN-1:0] ex_inp2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_illegal,
  output logic            halted,
  output logic [XLEN-1:0] issue_count
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SUB  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_MUL  = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_PASS = 4'b1111
  } alu_op_e;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IMM    = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;

  alu_op_e         d_op;
  logic [XLEN-1:0] d_inp1;
  logic [XLEN-1:0] d_inp2;
  logic [4:0]      d_rd;
  logic            d_rw;
  logic            d_mr;
  logic            d_mw;
  logic            d_br;
  logic            d_ill;
  logic            d_halt;
  logic            accept;

  assign opcode = id_instr[6:0];
  assign funct3 = id_instr[14:12];
  assign funct7 = id_instr[31:25];
  assign imm_i  = XLEN'($signed(id_instr[31:20]));
  assign imm_s  = XLEN'($signed({id_instr[31:25], id_instr[11:7]}));
  assign imm_u  = XLEN'($signed({id_instr[31:12], 12'b0}));
  assign shamt  = XLEN'(id_instr[24:20]);

  assign id_ready = !ex_stall && !halted;
  assign accept   = id_valid && id_ready && !flush;

  always_comb begin
    d_op   = ALU_PASS;
    d_inp1 = id_rs1_data;
    d_inp2 = id_rs2_data;
    d_rd   = id_instr[11:7];
    d_rw   = 1'b0;
    d_mr   = 1'b0;
    d_mw   = 1'b0;
    d_br   = 1'b0;
    d_ill  = 1'b0;
    d_halt = 1'b0;
    case (opcode)
      OP_R: begin
        d_rw = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  d_op = ALU_ADD;
            3'b001:  d_op = ALU_SLL;
            3'b011:  d_op = ALU_SLTU;
            3'b100:  d_op = ALU_XOR;
            3'b101:  d_op = ALU_SRL;
            3'b110:  d_op = ALU_OR;
            3'b111:  d_op = ALU_AND;
            default: d_ill = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          d_op = ALU_SUB;
        end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          d_op = ALU_MUL;
        end else begin
          d_ill = 1'b1;
        end
      end
      OP_IMM: begin
        d_rw   = 1'b1;
        d_inp2 = imm_i;
        case (funct3)
          3'b000: d_op = ALU_ADD;
          3'b011: d_op = ALU_SLTU;
          3'b100: d_op = ALU_XOR;
          3'b110: d_op = ALU_OR;
          3'b111: d_op = ALU_AND;
          3'b001: begin
            d_op   = ALU_SLL;
            d_inp2 = shamt;
            d_ill  = (funct7 != 7'b0000000);
          end
          3'b101: begin
            d_op   = ALU_SRL;
            d_inp2 = shamt;
            d_ill  = (funct7 != 7'b0000000);
          end
          default: d_ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        d_op   = ALU_ADD;
        d_inp2 = imm_i;
        d_mr   = 1'b1;
        d_rw   = 1'b1;
      end
      OP_STORE: begin
        d_op   = ALU_ADD;
        d_inp2 = imm_s;
        d_mw   = 1'b1;
      end
      OP_BRANCH: begin
        d_op = ALU_SUB;
        d_br = 1'b1;
        d_rd = '0;
      end
      OP_LUI: begin
        d_op   = ALU_ADD;
        d_inp1 = '0;
        d_inp2 = imm_u;
        d_rw   = 1'b1;
      end
      OP_SYSTEM: begin
        if (id_instr == 32'h0000_0073 ||
            (HALT_ON_EBREAK && id_instr == 32'h0010_0073)) begin
          d_op   = ALU_ADD;
          d_halt = 1'b1;
        end else begin
          d_ill = 1'b1;
        end
      end
      default: d_ill = 1'b1;
    endcase
    // Illegal words must never produce side effects, whatever branch flagged them.
    if (d_ill) begin
      d_op = ALU_PASS;
      d_rw = 1'b0;
      d_mr = 1'b0;
      d_mw = 1'b0;
      d_br = 1'b0;
    end
    if (d_rd == 5'd0) d_rw = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_alu_control <= ALU_PASS;
      ex_inp1        <= '0;
      ex_inp2        <= '0;
      ex_store_data  <= '0;
      ex_rd          <= '0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_illegal     <= 1'b0;
      halted         <= 1'b0;
      issue_count    <= '0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (ex_stall) begin
      ex_valid <= ex_valid;
    end else if (accept) begin
      ex_valid       <= 1'b1;
      ex_alu_control <= d_op;
      ex_inp1        <= d_inp1;
      ex_inp2        <= d_inp2;
      ex_store_data  <= id_rs2_data;
      ex_rd          <= d_rd;
      ex_reg_write   <= d_rw;
      ex_mem_read    <= d_mr;
      ex_mem_write   <= d_mw;
      ex_branch      <= d_br;
      ex_illegal     <= d_ill;
      issue_count    <= issue_count + XLEN'(1);
      if (d_halt) halted <= 1'b1;
    end else begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
      ex_illegal   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected EX bundles are queued when an
// instruction is presented and compared once the EX register has captured it.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic        ex_stall;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_inp1;
  logic [31:0] ex_inp2;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_illegal;
  logic        halted;
  logic [31:0] issue_count;

  typedef struct packed {
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] inp1;
    logic [31:0] inp2;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        ill;
  } bundle_t;

  bundle_t     obs;
  bundle_t     q[$];
  int          checks;
  int          errors;
  logic [31:0] exp_count;

  assign obs = {ex_valid, ex_alu_control, ex_inp1, ex_inp2, ex_store_data, ex_rd,
                ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal};

  alu_issue_stage #(.XLEN(32), .HALT_ON_EBREAK(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .ex_stall       (ex_stall),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_inp1        (ex_inp1),
    .ex_inp2        (ex_inp2),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_branch      (ex_branch),
    .ex_illegal     (ex_illegal),
    .halted         (halted),
    .issue_count    (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bundle_t mk(input logic v, input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] s, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic mw, input logic br,
                                 input logic il);
    bundle_t r;
    r = {v, c, a, b, s, rd, rw, mr, mw, br, il};
    return r;
  endfunction

  task automatic test_reset();
    bundle_t e;
    rst_n = 1'b0; id_valid = 1'b0; id_instr = '0; id_rs1_data = '0; id_rs2_data = '0;
    ex_stall = 1'b0; flush = 1'b0;
    tick();
    e = mk(1'b0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_bundle got=%h want=%h", obs, e); end
    checks++;
    if ({halted, id_ready} !== 2'b01) begin
      errors++; $display("FAIL reset_halt_ready got=%b want=01", {halted, id_ready});
    end
    checks++;
    if (issue_count !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", issue_count); end
    rst_n = 1'b1;
    exp_count = '0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins[11];
    logic [31:0] a[11];
    logic [31:0] b[11];
    bundle_t     ex[11];
    bundle_t     e;
    ins[0]  = 32'h002081B3; a[0]  = 32'd5;     b[0]  = 32'd7;
    ex[0]   = mk(1, 4'b0010, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0, 0);
    ins[1]  = 32'hFFF00093; a[1]  = 32'd0;     b[1]  = 32'h55;
    ex[1]   = mk(1, 4'b0010, 32'd0, 32'hFFFFFFFF, 32'h55, 5'd1, 1, 0, 0, 0, 0);
    ins[2]  = 32'h402081B3; a[2]  = 32'd9;     b[2]  = 32'd4;
    ex[2]   = mk(1, 4'b0100, 32'd9, 32'd4, 32'd4, 5'd3, 1, 0, 0, 0, 0);
    ins[3]  = 32'h022081B3; a[3]  = 32'd3;     b[3]  = 32'd6;
    ex[3]   = mk(1, 4'b0110, 32'd3, 32'd6, 32'd6, 5'd3, 1, 0, 0, 0, 0);
    ins[4]  = 32'h0040D093; a[4]  = 32'h80;    b[4]  = 32'h33;
    ex[4]   = mk(1, 4'b0101, 32'h80, 32'd4, 32'h33, 5'd1, 1, 0, 0, 0, 0);
    ins[5]  = 32'h0020A423; a[5]  = 32'h100;   b[5]  = 32'hDEADBEEF;
    ex[5]   = mk(1, 4'b0010, 32'h100, 32'd8, 32'hDEADBEEF, 5'd8, 0, 0, 1, 0, 0);
    ins[6]  = 32'h00208033; a[6]  = 32'd1;     b[6]  = 32'd2;
    ex[6]   = mk(1, 4'b0010, 32'd1, 32'd2, 32'd2, 5'd0, 0, 0, 0, 0, 0);
    ins[7]  = 32'h00208463; a[7]  = 32'd10;    b[7]  = 32'd3;
    ex[7]   = mk(1, 4'b0100, 32'd10, 32'd3, 32'd3, 5'd0, 0, 0, 0, 1, 0);
    ins[8]  = 32'h00C0A283; a[8]  = 32'h200;   b[8]  = 32'd0;
    ex[8]   = mk(1, 4'b0010, 32'h200, 32'd12, 32'd0, 5'd5, 1, 1, 0, 0, 0);
    ins[9]  = 32'h123453B7; a[9]  = 32'hAAAA;  b[9]  = 32'd0;
    ex[9]   = mk(1, 4'b0010, 32'd0, 32'h12345000, 32'd0, 5'd7, 1, 0, 0, 0, 0);
    ins[10] = 32'h0020F1B3; a[10] = 32'hF0F0;  b[10] = 32'h0FF0;
    ex[10]  = mk(1, 4'b0000, 32'hF0F0, 32'h0FF0, 32'h0FF0, 5'd3, 1, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      id_valid = 1'b1; id_instr = ins[i]; id_rs1_data = a[i]; id_rs2_data = b[i];
      q.push_back(ex[i]);
      exp_count = exp_count + 1;
      tick();
      checks++;
      if (q.size() == 0) begin
        errors++; $display("FAIL b2b_queue_empty idx=%0d", i);
      end else begin
        e = q.pop_front();
        if (obs !== e) begin errors++; $display("FAIL b2b_bundle idx=%0d got=%h want=%h", i, obs, e); end
      end
      checks++;
      if (issue_count !== exp_count) begin
        errors++; $display("FAIL b2b_count idx=%0d got=%0d want=%0d", i, issue_count, exp_count);
      end
    end
    id_valid = 1'b0;
  endtask

  task automatic test_illegal();
    logic [31:0] ins[4];
    logic [8:0]  got;
    ins[0] = 32'h00000000;
    ins[1] = 32'h0020A1B3;
    ins[2] = 32'h4040D093;
    ins[3] = 32'h0000006F;
    for (int i = 0; i < 4; i++) begin
      id_valid = 1'b1; id_instr = ins[i]; id_rs1_data = 32'h11; id_rs2_data = 32'h22;
      exp_count = exp_count + 1;
      tick();
      got = {ex_valid, ex_illegal, ex_alu_control, ex_reg_write, ex_mem_read, ex_mem_write};
      checks++;
      if (got !== 9'b1_1_1111_000) begin
        errors++; $display("FAIL illegal_flags word=%h got=%b want=111111000", ins[i], got);
      end
    end
    checks++;
    if (issue_count !== exp_count) begin
      errors++; $display("FAIL illegal_count got=%0d want=%0d", issue_count, exp_count);
    end
    id_valid = 1'b0;
  endtask

  task automatic test_stall_flush();
    bundle_t e;
    bundle_t last;
    last = '0;
    id_valid = 1'b1; id_instr = 32'h002081B3; id_rs1_data = 32'd5; id_rs2_data = 32'd7;
    q.push_back(mk(1, 4'b0010, 32'd5, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0, 0));
    exp_count = exp_count + 1;
    tick();
    checks++;
    if (q.size() == 0) begin
      errors++; $display("FAIL stall_load_queue_empty");
    end else begin
      e = q.pop_front();
      last = e;
      if (obs !== e) begin errors++; $display("FAIL stall_load got=%h want=%h", obs, e); end
    end
    ex_stall = 1'b1; id_instr = 32'h402081B3; id_rs1_data = 32'd99; id_rs2_data = 32'd98;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== last) begin errors++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, obs, last); end
      checks++;
      if ({id_ready, issue_count} !== {1'b0, exp_count}) begin
        errors++; $display("FAIL stall_ready_count cyc=%0d got=%b/%0d want=0/%0d", i, id_ready, issue_count, exp_count);
      end
    end
    flush = 1'b1;
    tick();
    checks++;
    if ({ex_valid, ex_reg_write} !== 2'b00) begin
      errors++; $display("FAIL flush_valid got=%b want=00", {ex_valid, ex_reg_write});
    end
    checks++;
    if (issue_count !== exp_count) begin
      errors++; $display("FAIL flush_count got=%0d want=%0d", issue_count, exp_count);
    end
    flush = 1'b0; ex_stall = 1'b0; id_valid = 1'b0;
    tick();
    checks++;
    if ({ex_valid, issue_count} !== {1'b0, exp_count}) begin
      errors++; $display("FAIL bubble got=%b/%0d want=0/%0d", ex_valid, issue_count, exp_count);
    end
  endtask

  task automatic test_halt();
    id_valid = 1'b1; id_instr = 32'h00000073; id_rs1_data = '0; id_rs2_data = '0; flush = 1'b1;
    tick();
    checks++;
    if ({halted, ex_valid, issue_count} !== {2'b00, exp_count}) begin
      errors++; $display("FAIL halt_flush got=%b%b/%0d want=00/%0d", halted, ex_valid, issue_count, exp_count);
    end
    flush = 1'b0;
    exp_count = exp_count + 1;
    tick();
    checks++;
    if ({ex_valid, ex_alu_control, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write} !== 9'b1_0010_0000) begin
      errors++; $display("FAIL ecall_bundle got=%b want=100100000",
                         {ex_valid, ex_alu_control, ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write});
    end
    checks++;
    if ({halted, id_ready, issue_count} !== {2'b10, exp_count}) begin
      errors++; $display("FAIL ecall_halt got=%b%b/%0d want=10/%0d", halted, id_ready, issue_count, exp_count);
    end
    id_instr = 32'h002081B3; id_rs1_data = 32'd5; id_rs2_data = 32'd7;
    tick();
    checks++;
    if ({ex_valid, halted, issue_count} !== {2'b01, exp_count}) begin
      errors++; $display("FAIL halted_block got=%b%b/%0d want=01/%0d", ex_valid, halted, issue_count, exp_count);
    end
    rst_n = 1'b0; id_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_count = '0;
    checks++;
    if ({halted, ex_valid, ex_alu_control, issue_count} !== {2'b00, 4'hF, 32'd0}) begin
      errors++; $display("FAIL halt_reset got=%b%b%h/%0d want=00f/0", halted, ex_valid, ex_alu_control, issue_count);
    end
    id_valid = 1'b1; id_instr = 32'h00100073;
    exp_count = exp_count + 1;
    tick();
    checks++;
    if ({halted, ex_valid, ex_alu_control, issue_count} !== {2'b11, 4'b0010, exp_count}) begin
      errors++; $display("FAIL ebreak_halt got=%b%b%h/%0d want=112/%0d", halted, ex_valid, ex_alu_control, issue_count, exp_count);
    end
    id_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_count = '0;
    test_reset();
    test_back_to_back();
    test_illegal();
    test_stall_flush();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
